// File: rtl/m_serialshift_pkg.sv
// Shared encodings and the single-step shift helper for the bit-serial shifter.
package m_serialshift_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned SHW  = 5;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    // One bit position per call; the reserved encoding falls through to SRL.
    function automatic logic [XLEN-1:0] shift_one(input logic [1:0] op,
                                                  input logic [XLEN-1:0] val);
        case (op)
            SH_SLL:  return {val[XLEN-2:0], 1'b0};
            SH_SRA:  return {val[XLEN-1], val[XLEN-1:1]};
            default: return {1'b0, val[XLEN-1:1]};
        endcase
    endfunction

endpackage

// File: rtl/m_shcount_dn.sv
// Loadable 5-bit down counter with equality flags for one and zero.
module m_shcount_dn
    import m_serialshift_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           dec,
    input  logic [SHW-1:0] din,
    output logic [SHW-1:0] cnt,
    output logic           is_one,
    output logic           is_zero
);

    logic [SHW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= din;
        end else if (dec) begin
            cnt_q <= cnt_q - SHW'(1);
        end
    end

    assign cnt     = cnt_q;
    assign is_one  = (cnt_q == SHW'(1));
    assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/m_serialshift.sv
// Bit-serial RV32 shift stage: shifts one position per clock, pulses done when finished.
module m_serialshift
    import m_serialshift_pkg::*;
#(
    parameter int unsigned XLEN_P = 32  // only 32 is supported
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [XLEN_P-1:0] operand,
    input  logic [SHW-1:0]    shamt,
    output logic              busy,
    output logic              lastshift,
    output logic              issh0,
    output logic              done,
    output logic [XLEN_P-1:0] result
);

    state_e            state_q;
    logic [XLEN-1:0]   result_q;
    logic [1:0]        opr_q;
    logic              issh0_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic              in_shift;
    logic [SHW-1:0]    cnt;
    logic              cnt_is_one;
    logic              cnt_is_zero;
    logic              unused_cnt;

    assign accept   = (state_q == StIdle) && start;
    assign in_shift = (state_q == StShift);

    m_shcount_dn u_count (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .dec     (in_shift),
        .din     (shamt),
        .cnt     (cnt),
        .is_one  (cnt_is_one),
        .is_zero (cnt_is_zero)
    );

    assign unused_cnt = ^cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            opr_q    <= SH_SLL;
            issh0_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        result_q <= operand;
                        opr_q    <= op;
                        issh0_q  <= (shamt == '0);
                        busy_q   <= 1'b1;
                        done_q   <= (shamt == '0);
                        state_q  <= (shamt == '0) ? StDone : StShift;
                    end
                end
                StShift: begin
                    result_q <= shift_one(opr_q, result_q);
                    // is_zero is unreachable here; treated as a safe exit rather than a wrap
                    if (cnt_is_one || cnt_is_zero) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign issh0     = issh0_q;
    assign result    = result_q;
    assign lastshift = in_shift && cnt_is_one;

endmodule

// File: tb/tb_m_serialshift.sv
// Directed self-checking bench for the bit-serial shifter.
module tb_m_serialshift;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand = 32'h0;
    logic [4:0]  shamt = 5'd0;
    logic        busy;
    logic        lastshift;
    logic        issh0;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    m_serialshift dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand   (operand),
        .shamt     (shamt),
        .busy      (busy),
        .lastshift (lastshift),
        .issh0     (issh0),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one accept in cycle k, scramble inputs afterwards, then track done and lastshift.
    task automatic run_shift(input string tag, input logic [1:0] o, input logic [31:0] a,
                             input logic [4:0] s, input logic [31:0] exp);
        int cyc;
        int ls_cnt;
        int ls_at;
        @(negedge clk);
        start = 1'b1; op = o; operand = a; shamt = s;
        @(negedge clk);
        start = 1'b0; op = o ^ 2'b01; operand = ~a; shamt = ~s;
        cyc = 1; ls_cnt = 0; ls_at = -1;
        check_eq({tag, ".busy"}, 32'(busy), 32'd1);
        while (!done && cyc < 40) begin
            if (lastshift) begin
                ls_cnt++;
                ls_at = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, ".lat"}, 32'(cyc), 32'(1 + int'(s)));
        check_eq({tag, ".result"}, result, exp);
        check_eq({tag, ".issh0"}, 32'(issh0), 32'(s == 5'd0));
        check_eq({tag, ".ls_cnt"}, 32'(ls_cnt), (s == 5'd0) ? 32'd0 : 32'd1);
        if (s != 5'd0) check_eq({tag, ".ls_at"}, 32'(ls_at), 32'(s));
        @(negedge clk);
        check_eq({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".idle_done"}, 32'(done), 32'd0);
        check_eq({tag, ".hold"}, result, exp);
    endtask

    initial begin
        #2;
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        check_eq("rst.result", result, 32'h0);
        check_eq("rst.issh0", 32'(issh0), 32'd0);
        check_eq("rst.lastshift", 32'(lastshift), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-SHIFT: accept at k, reset at k+5.
        @(negedge clk);
        start = 1'b1; op = 2'b00; operand = 32'h0000_0001; shamt = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("abort.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort.busy", 32'(busy), 32'd0);
        check_eq("abort.result", result, 32'h0);
        check_eq("abort.done", 32'(done), 32'd0);
        begin
            int seen_done = 0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (done) seen_done++;
                if (i == 2) rst_n = 1'b1;
            end
            check_eq("abort.no_done", 32'(seen_done), 32'd0);
        end
        run_shift("after_rst", 2'b00, 32'h0000_0001, 5'd20, 32'h0010_0000);

        run_shift("zero", 2'b00, 32'h8000_0001, 5'd0, 32'h8000_0001);
        run_shift("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run_shift("srl4", 2'b01, 32'hF000_000F, 5'd4, 32'h0F00_0000);
        run_shift("rsv4", 2'b11, 32'hF000_000F, 5'd4, 32'h0F00_0000);
        run_shift("sll1", 2'b00, 32'h8000_0001, 5'd1, 32'h0000_0002);
        run_shift("sra_pos", 2'b10, 32'h4000_0000, 5'd30, 32'h0000_0001);

        // start held high: accepts at c=0 and c=5, done at c=4 and c=9.
        @(negedge clk);
        start = 1'b1; op = 2'b00; operand = 32'h1; shamt = 5'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check_eq($sformatf("coll.done%0d", c), 32'(done), 32'((c == 4) || (c == 9)));
            check_eq($sformatf("coll.busy%0d", c), 32'(busy),
                     32'((c >= 1 && c <= 4) || (c >= 6 && c <= 9)));
            if (c == 4 || c == 9) check_eq($sformatf("coll.res%0d", c), result, 32'h8);
            if ((c >= 1 && c <= 3) || (c >= 6 && c <= 8)) begin
                op = 2'b10; operand = 32'hDEAD_BEEF; shamt = 5'd0;
            end else begin
                op = 2'b00; operand = 32'h1; shamt = 5'd3;
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("coll.end_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
